// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: MSB-first digit-serial magnitude compare, DIGIT bits per clock,
// unsigned or two's-complement, with start/busy/done handshake and held results.
module seq_magnitude_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2,
    parameter int EARLY_EXIT = 1,
    localparam int NDIG = WIDTH / DIGIT,
    localparam int CW = $clog2(NDIG) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             a_eq_b,
    output logic [CW-1:0]    cycles
);
    localparam logic [0:0] IDLE = 1'b0, COMPARE = 1'b1;
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (WIDTH < 2 || WIDTH % DIGIT != 0) begin : g_bad_params
            $error("seq_magnitude_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    logic [0:0]       state;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]    cnt;
    logic             rec_gt, rec_lt;
    logic [DIGIT-1:0] da, db;
    logic             dgt, dlt, found, fin;

    assign da    = sa[WIDTH-1 -: DIGIT];
    assign db    = sb[WIDTH-1 -: DIGIT];
    assign dgt   = da > db;
    assign dlt   = da < db;
    assign found = rec_gt | rec_lt;
    assign fin   = cnt == CW'(1) || (EARLY_EXIT != 0 && (dgt || dlt));

    // Flipping both MSBs maps two's-complement order onto unsigned order
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            a_gt_b <= 1'b0;
            a_lt_b <= 1'b0;
            a_eq_b <= 1'b0;
            cycles <= '0;
            cnt    <= '0;
            sa     <= '0;
            sb     <= '0;
            rec_gt <= 1'b0;
            rec_lt <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    sa     <= signed_mode ? a ^ MSB : a;
                    sb     <= signed_mode ? b ^ MSB : b;
                    a_gt_b <= 1'b0;
                    a_lt_b <= 1'b0;
                    a_eq_b <= 1'b0;
                    cycles <= '0;
                    cnt    <= CW'(NDIG);
                    rec_gt <= 1'b0;
                    rec_lt <= 1'b0;
                    busy   <= 1'b1;
                    state  <= COMPARE;
                end
            end else begin
                cycles <= cycles + CW'(1);
                sa     <= sa << DIGIT;
                sb     <= sb << DIGIT;
                cnt    <= cnt - CW'(1);
                if (!found) begin
                    rec_gt <= dgt;
                    rec_lt <= dlt;
                end
                if (fin) begin
                    a_gt_b <= found ? rec_gt : dgt;
                    a_lt_b <= found ? rec_lt : dlt;
                    a_eq_b <= !found && !dgt && !dlt;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb_seq_magnitude_comparator: four configurations checked every cycle against an arithmetic
// model, plus directed vectors with hand-computed results.
module tb_seq_magnitude_comparator;
    localparam int PW[4] = '{8, 8, 8, 16};
    localparam int PD[4] = '{2, 2, 8, 1};
    localparam int PE[4] = '{1, 0, 1, 1};

    typedef struct packed {
        logic [4:0] n;
        logic       gt;
        logic       lt;
        logic       eq;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start[4];
    logic        sm[4];
    logic [15:0] op_a[4], op_b[4];
    logic        busy_o[4], done_o[4], gt_o[4], lt_o[4], eq_o[4];
    logic [4:0]  cyc_o[4];
    logic [2:0]  c0, c1;
    logic [0:0]  c2;
    logic [4:0]  c3;
    int          passed = 0, total = 0;
    bit          armed = 1'b0;

    logic        m_busy[4], m_done[4], m_have[4];
    int          m_el[4];
    res_t        m_res[4];

    assign cyc_o[0] = {2'b0, c0};
    assign cyc_o[1] = {2'b0, c1};
    assign cyc_o[2] = {4'b0, c2};
    assign cyc_o[3] = c3;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .signed_mode(sm[0]),
        .a(op_a[0][7:0]), .b(op_b[0][7:0]), .busy(busy_o[0]), .done(done_o[0]),
        .a_gt_b(gt_o[0]), .a_lt_b(lt_o[0]), .a_eq_b(eq_o[0]), .cycles(c0));
    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .signed_mode(sm[1]),
        .a(op_a[1][7:0]), .b(op_b[1][7:0]), .busy(busy_o[1]), .done(done_o[1]),
        .a_gt_b(gt_o[1]), .a_lt_b(lt_o[1]), .a_eq_b(eq_o[1]), .cycles(c1));
    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(8), .EARLY_EXIT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .signed_mode(sm[2]),
        .a(op_a[2][7:0]), .b(op_b[2][7:0]), .busy(busy_o[2]), .done(done_o[2]),
        .a_gt_b(gt_o[2]), .a_lt_b(lt_o[2]), .a_eq_b(eq_o[2]), .cycles(c2));
    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(1), .EARLY_EXIT(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start[3]), .signed_mode(sm[3]),
        .a(op_a[3]), .b(op_b[3]), .busy(busy_o[3]), .done(done_o[3]),
        .a_gt_b(gt_o[3]), .a_lt_b(lt_o[3]), .a_eq_b(eq_o[3]), .cycles(c3));

    // Result by integer compare; latency is the shortest MSB prefix in which the operands differ
    function automatic res_t predict(int w, int d, int ee, logic s, logic [15:0] a, logic [15:0] b);
        res_t   r;
        longint ua, ub, va, vb;
        int     nd;
        ua = longint'(a) & ((longint'(1) << w) - 1);
        ub = longint'(b) & ((longint'(1) << w) - 1);
        va = (s && ua[w-1]) ? ua - (longint'(1) << w) : ua;
        vb = (s && ub[w-1]) ? ub - (longint'(1) << w) : ub;
        r.gt = va > vb;
        r.lt = va < vb;
        r.eq = va == vb;
        nd = w / d;
        r.n = 5'(nd);
        if (ee != 0)
            for (int k = nd; k >= 1; k--)
                if ((ua >> (w - k * d)) != (ub >> (w - k * d))) r.n = 5'(k);
        return r;
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(posedge clk)
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_have[i] <= 1'b0;
                m_el[i]   <= 0;
            end else begin
                m_done[i] <= 1'b0;
                if (!m_busy[i] && start[i]) begin
                    m_res[i]  <= predict(PW[i], PD[i], PE[i], sm[i], op_a[i], op_b[i]);
                    m_busy[i] <= 1'b1;
                    m_have[i] <= 1'b0;
                    m_el[i]   <= 0;
                end else if (m_busy[i]) begin
                    if (m_el[i] + 1 == int'(m_res[i].n)) begin
                        m_busy[i] <= 1'b0;
                        m_done[i] <= 1'b1;
                        m_have[i] <= 1'b1;
                    end
                    m_el[i] <= m_el[i] + 1;
                end
            end
        end

    always @(negedge clk)
        if (armed)
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("busy%0d", i), 16'(busy_o[i]), 16'(m_busy[i]));
                chk($sformatf("done%0d", i), 16'(done_o[i]), 16'(m_done[i]));
                chk($sformatf("gt%0d", i), 16'(gt_o[i]), 16'(m_have[i] & m_res[i].gt));
                chk($sformatf("lt%0d", i), 16'(lt_o[i]), 16'(m_have[i] & m_res[i].lt));
                chk($sformatf("eq%0d", i), 16'(eq_o[i]), 16'(m_have[i] & m_res[i].eq));
                if (!m_busy[i])
                    chk($sformatf("cycles%0d", i), 16'(cyc_o[i]), m_have[i] ? 16'(m_res[i].n) : 16'd0);
            end

    task automatic run(int i, logic s, logic [15:0] a, logic [15:0] b,
                       logic eg, logic el, logic ee, int ec, int lat, string nm);
        int k;
        start[i] = 1'b1;
        sm[i]    = s;
        op_a[i]  = a;
        op_b[i]  = b;
        @(negedge clk);
        start[i] = 1'b0;
        op_a[i]  = ~a;
        op_b[i]  = a;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done_o[i] && k < 40);
        chk({nm, "_lat"}, 16'(k), 16'(lat));
        chk({nm, "_gt"}, 16'(gt_o[i]), 16'(eg));
        chk({nm, "_lt"}, 16'(lt_o[i]), 16'(el));
        chk({nm, "_eq"}, 16'(eq_o[i]), 16'(ee));
        chk({nm, "_cyc"}, 16'(cyc_o[i]), 16'(ec));
    endtask

    initial begin
        int  d;
        bit  first;
        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b0;
            sm[i]    = 1'b0;
            op_a[i]  = '0;
            op_b[i]  = '0;
        end
        repeat (2) @(negedge clk);
        armed = 1'b1;
        chk("rst_busy", 16'(busy_o[0]), 16'd0);
        chk("rst_flags", 16'({gt_o[0], lt_o[0], eq_o[0]}), 16'd0);
        chk("rst_cyc", 16'(cyc_o[3]), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 1'b0, 16'h00C0, 16'h0040, 1, 0, 0, 1, 1, "ee_c0_40");
        run(0, 1'b0, 16'h005A, 16'h005A, 0, 0, 1, 4, 4, "ee_5a_5a");
        run(0, 1'b0, 16'h0012, 16'h0013, 0, 1, 0, 4, 4, "ee_12_13");
        run(0, 1'b1, 16'h00FF, 16'h0001, 0, 1, 0, 1, 1, "s_ff_01");
        run(0, 1'b0, 16'h00FF, 16'h0001, 1, 0, 0, 1, 1, "u_ff_01");
        run(0, 1'b1, 16'h0080, 16'h007F, 0, 1, 0, 1, 1, "s_80_7f");
        run(1, 1'b0, 16'h00C0, 16'h0040, 1, 0, 0, 4, 4, "cl_c0_40");
        run(1, 1'b0, 16'h0012, 16'h0013, 0, 1, 0, 4, 4, "cl_12_13");
        run(2, 1'b0, 16'h00C0, 16'h0040, 1, 0, 0, 1, 1, "d8_c0_40");
        run(2, 1'b0, 16'h005A, 16'h005A, 0, 0, 1, 1, 1, "d8_5a_5a");
        run(2, 1'b1, 16'h0080, 16'h007F, 0, 1, 0, 1, 1, "d8_s80_7f");
        run(3, 1'b0, 16'h8000, 16'h8001, 0, 1, 0, 16, 16, "w16_8000_8001");
        run(3, 1'b1, 16'h8000, 16'h0001, 0, 1, 0, 1, 1, "w16_s8000_0001");

        // Hold start through the whole op with churning operands
        start[0] = 1'b1;
        sm[0]    = 1'b0;
        op_a[0]  = 16'h005A;
        op_b[0]  = 16'h005A;
        first    = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            op_a[0] = 16'(j * 37);
            op_b[0] = 16'(j * 53 + 1);
            if (done_o[0] && first) begin
                chk("hs_lat", 16'(j), 16'd4);
                chk("hs_eq", 16'(eq_o[0]), 16'd1);
                chk("hs_cyc", 16'(cyc_o[0]), 16'd4);
                first = 1'b0;
            end
            if (j == 5) chk("hs_b2b_busy", 16'(busy_o[0]), 16'd1);
        end
        chk("hs_seen", 16'(first), 16'd0);
        start[0] = 1'b0;
        d = 0;
        while (busy_o[0] && d < 40) begin
            @(negedge clk);
            d++;
        end
        chk("hs_idle", 16'(busy_o[0]), 16'd0);

        // Reset sampled at the second COMPARE edge aborts the op
        start[0] = 1'b1;
        op_a[0]  = 16'h005A;
        op_b[0]  = 16'h005A;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rmid_busy", 16'(busy_o[0]), 16'd0);
        chk("rmid_done", 16'(done_o[0]), 16'd0);
        chk("rmid_flags", 16'({gt_o[0], lt_o[0], eq_o[0]}), 16'd0);
        chk("rmid_cyc", 16'(cyc_o[0]), 16'd0);
        rst_n = 1'b1;
        d = 0;
        repeat (8) begin
            @(negedge clk);
            d += int'(done_o[0]);
        end
        chk("rmid_no_done", 16'(d), 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Parametrised, multi-cycle magnitude comparator that generalises the 2-bit combinational comparator to WIDTH-bit operands. It scans the operands MSB-first, DIGIT bits per clock, and optionally stops at the first differing digit. It supports unsigned and two's-complement comparison and uses a start/busy/done handshake. Results are registered and held until the next accepted start. It is intended as the reusable compare unit for datapath and sorting blocks.

Parameters:
WIDTH, 8, operand width in bits; must be >= 2.
DIGIT, 2, bits compared per clock; WIDTH % DIGIT must be 0, otherwise elaboration error; DIGIT = WIDTH gives a single-cycle compare.
EARLY_EXIT, 1, 1 = finish at first differing digit; 0 = always scan all NDIG = WIDTH/DIGIT digits (constant latency).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; accepted only when busy=0
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while a compare is in progress
done  output  1  one-cycle pulse; result valid
a_gt_b  output  1  A > B, held
a_lt_b  output  1  A < B, held
a_eq_b  output  1  A == B, held
cycles  output  $clog2(NDIG)+1  number of COMPARE cycles used by the last operation, held

Behaviour:
- Reset: on a clk edge with rst_n=0, state goes to IDLE. busy, done, a_gt_b, a_lt_b, a_eq_b and cycles all become 0. Reset applies in any state and aborts an operation in progress; no done is produced for it.
- FSM has two states: IDLE and COMPARE.
- IDLE, start=1 at an edge:
  - Latch a and b into internal shift registers sa and sb.
  - If signed_mode=1, invert the MSB of both latched values (offset-binary), so the unsigned scan gives the signed order.
  - Clear all three flags and cycles; load the digit counter with NDIG; set busy=1; go to COMPARE.
- COMPARE, each edge:
  - Compare the top DIGIT bits of sa and sb as unsigned values and increment cycles.
  - Record the first inequality only; later digits never override it.
  - EARLY_EXIT=1: on a differing digit, set a_gt_b or a_lt_b, pulse done, clear busy, return to IDLE.
  - Equal digit: shift sa and sb left by DIGIT and decrement the counter. If it was the last digit, set a_eq_b=1, pulse done, clear busy, return to IDLE.
  - EARLY_EXIT=0: always run NDIG cycles, then load the flag from the recorded first difference (eq if none).
- Latency: the start edge is edge 0; results and done appear after edge n, where n = 1..NDIG (EARLY_EXIT=1) or n = NDIG (EARLY_EXIT=0).
- Exactly one flag is high after any done; all three are 0 while busy and after reset.
- done is high for exactly one cycle. Flags and cycles hold until the next accepted start or reset.
- start while busy=1 is ignored: no queuing, no effect on the latched operands.
- start in the cycle that done is high is accepted (state is IDLE), giving back-to-back operations with no idle gap.
- Operand inputs may change freely after the start edge.

Test Plan:
- Reset mid-op: WIDTH=8, DIGIT=2; start with a=0x5A, b=0x5A; drive rst_n=0 at the 2nd COMPARE edge → next cycle busy=0, done=0, all flags 0, cycles=0, and no done pulse afterwards.
- Early exit, unsigned, EARLY_EXIT=1: a=0xC0, b=0x40 → done after edge 1, a_gt_b=1, cycles=1. Then a=0x5A, b=0x5A → done after edge 4, a_eq_b=1, cycles=4. Then a=0x12, b=0x13 → a_lt_b=1, cycles=4.
- Signed vs unsigned: a=0xFF, b=0x01. With signed_mode=1 → a_lt_b=1, cycles=1. With signed_mode=0 → a_gt_b=1, cycles=1. Also a=0x80, b=0x7F with signed_mode=1 → a_lt_b=1.
- Constant latency, EARLY_EXIT=0: a=0xC0, b=0x40 → done only after edge 4, a_gt_b=1 (first difference kept), cycles=4.
- Handshake: assert start continuously with changing a/b while busy → operands of the first op unaffected. start held high through the done cycle → second op accepted that edge and busy stays 1.
- Corner configurations: DIGIT=WIDTH=8 → every compare finishes in 1 cycle. WIDTH=16, DIGIT=1, a=0x8000, b=0x8001, unsigned → a_lt_b=1, cycles=16.
